// File: rtl/fi_pkg.sv
// Shared types for the fault-injection controller.
// Fault modes and FSM states.
package fi_pkg;

  typedef enum logic [1:0] {
    FI_NONE = 2'b00,
    FI_FLIP = 2'b01,
    FI_SA0  = 2'b10,
    FI_SA1  = 2'b11
  } fi_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } fi_state_e;

endpackage

// File: rtl/fi_fault_apply.sv
// Combinational single-bit fault applier.
// Kept separate so it can be replicated per channel.
module fi_fault_apply
  import fi_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int BIT_W  = $clog2(DATA_W)
) (
  input  logic [1:0]        mode,
  input  logic [BIT_W-1:0]  bit_sel,
  input  logic              active,
  input  logic [DATA_W-1:0] sig_i,
  output logic [DATA_W-1:0] sig_o
);

  logic [DATA_W-1:0] mask;

  always_comb begin
    mask  = DATA_W'(1) << bit_sel;
    sig_o = sig_i;
    if (active) begin
      case (mode)
        FI_FLIP: sig_o = sig_i ^ mask;
        FI_SA0:  sig_o = sig_i & ~mask;
        FI_SA1:  sig_o = sig_i | mask;
        default: sig_o = sig_i;
      endcase
    end
  end

endmodule

// File: rtl/fi_inject_ctrl.sv
// Fault-injection run controller: shadow config, cycle
// counter, fault window and first-mismatch latch.
module fi_inject_ctrl
  import fi_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16,
  parameter int BIT_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        cfg_mode,
  input  logic [BIT_W-1:0]  cfg_bit,
  input  logic [CNT_W-1:0]  cfg_inject_cycle,
  input  logic [CNT_W-1:0]  cfg_duration,
  input  logic [CNT_W-1:0]  cfg_run_len,
  input  logic [DATA_W-1:0] sig_i,
  output logic [DATA_W-1:0] sig_o,
  input  logic [DATA_W-1:0] obs_i,
  input  logic [DATA_W-1:0] gold_i,
  output logic [CNT_W-1:0]  clk_counter,
  output logic              busy,
  output logic              fault_active,
  output logic              mismatch,
  output logic [CNT_W-1:0]  mismatch_cycle,
  output logic              done
);

  localparam logic [31:0] DW = DATA_W;

  fi_state_e         state;
  fi_mode_e          sh_mode;
  logic [BIT_W-1:0]  sh_bit;
  logic [CNT_W-1:0]  sh_inject;
  logic [CNT_W-1:0]  sh_dur;
  logic [CNT_W-1:0]  sh_last;
  logic [CNT_W:0]    win_end;
  logic              bit_ok;
  logic              hit;

  assign busy    = (state == RUN);
  assign done    = (state == DONE);
  assign bit_ok  = 32'(sh_bit) < DW;
  // one extra bit so inject+duration never wraps
  assign win_end = {1'b0, sh_inject} + {1'b0, sh_dur};
  assign hit     = busy && (obs_i != gold_i) && !mismatch;

  assign fault_active = busy
    && (sh_mode != FI_NONE)
    && bit_ok
    && (clk_counter >= sh_inject)
    && ((sh_dur == '0) || ({1'b0, clk_counter} < win_end));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      clk_counter    <= '0;
      mismatch       <= 1'b0;
      mismatch_cycle <= '0;
      sh_mode        <= FI_NONE;
      sh_bit         <= '0;
      sh_inject      <= '0;
      sh_dur         <= '0;
      sh_last        <= '0;
    end else begin
      case (state)
        RUN: begin
          if (hit) begin
            mismatch       <= 1'b1;
            mismatch_cycle <= clk_counter;
          end
          if (clk_counter == sh_last)
            state <= DONE;
          else
            clk_counter <= clk_counter + CNT_W'(1);
        end
        IDLE, DONE: begin
          if (start) begin
            state          <= RUN;
            clk_counter    <= '0;
            mismatch       <= 1'b0;
            mismatch_cycle <= '0;
            sh_mode        <= fi_mode_e'(cfg_mode);
            sh_bit         <= cfg_bit;
            sh_inject      <= cfg_inject_cycle;
            sh_dur         <= cfg_duration;
            // zero length runs as a single cycle
            sh_last        <= (cfg_run_len == '0) ? '0
                              : cfg_run_len - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  fi_fault_apply #(
    .DATA_W (DATA_W),
    .BIT_W  (BIT_W)
  ) u_apply (
    .mode    (sh_mode),
    .bit_sel (sh_bit),
    .active  (fault_active),
    .sig_i   (sig_i),
    .sig_o   (sig_o)
  );

endmodule

// File: tb/tb_fi_inject_ctrl.sv
// Randomized bench for fi_inject_ctrl against a
// per-cycle reference model of the run rules.
module tb_fi_inject_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  cfg_mode;
  logic [6:0]  cfg_bit;
  logic [15:0] cfg_inject_cycle;
  logic [15:0] cfg_duration;
  logic [15:0] cfg_run_len;
  logic [63:0] sig_i;
  logic [63:0] sig_o;
  logic [63:0] obs_i;
  logic [63:0] gold_i;
  logic [15:0] clk_counter;
  logic        busy;
  logic        fault_active;
  logic        mismatch;
  logic [15:0] mismatch_cycle;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  fi_inject_ctrl #(
    .DATA_W (64),
    .CNT_W  (16),
    .BIT_W  (7)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .cfg_mode         (cfg_mode),
    .cfg_bit          (cfg_bit),
    .cfg_inject_cycle (cfg_inject_cycle),
    .cfg_duration     (cfg_duration),
    .cfg_run_len      (cfg_run_len),
    .sig_i            (sig_i),
    .sig_o            (sig_o),
    .obs_i            (obs_i),
    .gold_i           (gold_i),
    .clk_counter      (clk_counter),
    .busy             (busy),
    .fault_active     (fault_active),
    .mismatch         (mismatch),
    .mismatch_cycle   (mismatch_cycle),
    .done             (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input logic [63:0] s);
    chk("rst_counter", clk_counter, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fault", fault_active, 0);
    chk("rst_mismatch", mismatch, 0);
    chk("rst_mcyc", mismatch_cycle, 0);
    chk("rst_sig_o", sig_o, s);
  endtask

  task automatic run_exp(input int mode, input int bsel,
                         input int inj, input int dur,
                         input int len, input int ma,
                         input int mb, input bit chg,
                         input int rst_at, input bit zero);
    int          eff;
    int          fm;
    bit          act;
    logic [63:0] s;
    logic [63:0] g;
    logic [63:0] e;
    eff = (len == 0) ? 1 : len;
    fm  = -1;
    @(negedge clk);
    cfg_mode         = 2'(mode);
    cfg_bit          = 7'(bsel);
    cfg_inject_cycle = 16'(inj);
    cfg_duration     = 16'(dur);
    cfg_run_len      = 16'(len);
    start            = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < eff; k++) begin
      s      = zero ? 64'h0 : {$urandom, $urandom};
      g      = {$urandom, $urandom};
      sig_i  = s;
      gold_i = g;
      obs_i  = (k == ma || k == mb)
               ? g ^ (64'h1 << $urandom_range(63, 0)) : g;
      if (chg && k == 5) begin
        start            = 1'b1;
        cfg_mode         = 2'($urandom);
        cfg_bit          = 7'($urandom_range(63, 0));
        cfg_inject_cycle = 16'h0;
        cfg_duration     = 16'h0;
        cfg_run_len      = 16'd200;
      end
      if (chg && k == 6) start = 1'b0;
      #1;
      act = mode != 0 && bsel < 64 && k >= inj
            && (dur == 0 || k < inj + dur);
      e = s;
      if (act) e[bsel] = (mode == 1) ? ~s[bsel] : (mode == 3);
      chk("counter", clk_counter, 64'(k));
      chk("busy", busy, 1);
      chk("done", done, 0);
      chk("fault_active", fault_active, act);
      chk("sig_o", sig_o, e);
      chk("mismatch", mismatch, fm >= 0);
      chk("mismatch_cycle", mismatch_cycle, (fm >= 0) ? 64'(fm) : 0);
      if (fm < 0 && (k == ma || k == mb)) fm = k;
      if (k == rst_at) begin
        rst = 1'b1;
        #1;
        chk_zero(s);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("idle_counter", clk_counter, 0);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        return;
      end
      @(negedge clk);
    end
    s      = {$urandom, $urandom};
    sig_i  = s;
    obs_i  = ~gold_i;
    #1;
    chk("end_counter", clk_counter, 64'(eff - 1));
    chk("end_busy", busy, 0);
    chk("end_done", done, 1);
    chk("end_fault", fault_active, 0);
    chk("end_sig_o", sig_o, s);
    chk("end_mismatch", mismatch, fm >= 0);
    chk("end_mcyc", mismatch_cycle, (fm >= 0) ? 64'(fm) : 0);
    repeat (2) @(negedge clk);
    #1;
    chk("hold_counter", clk_counter, 64'(eff - 1));
    chk("hold_done", done, 1);
    chk("hold_mismatch", mismatch, fm >= 0);
    obs_i = gold_i;
  endtask

  initial begin
    rst              = 1'b1;
    start            = 1'b0;
    cfg_mode         = 2'b0;
    cfg_bit          = 7'h0;
    cfg_inject_cycle = 16'h0;
    cfg_duration     = 16'h0;
    cfg_run_len      = 16'h0;
    sig_i            = 64'h1234_5678_9abc_def0;
    obs_i            = 64'h0;
    gold_i           = 64'h0;
    #3;
    chk_zero(64'h1234_5678_9abc_def0);
    @(negedge clk);
    rst = 1'b0;

    run_exp(1, 5, 10, 3, 64, -1, -1, 0, -1, 1);
    run_exp(3, 63, 0, 0, 64, -1, -1, 0, -1, 1);
    run_exp(2, 7, 5, 0, 64, 20, 30, 0, -1, 0);
    run_exp(1, 3, 70, 0, 64, -1, -1, 0, -1, 0);
    run_exp(1, 64, 0, 0, 64, -1, -1, 0, -1, 0);
    run_exp(2, 0, 0, 0, 64, 63, -1, 0, -1, 0);
    run_exp(1, 9, 8, 4, 40, 12, -1, 1, -1, 0);
    run_exp(3, 2, 0, 0, 64, 4, -1, 0, 15, 0);
    run_exp(1, 0, 0, 1, 0, 0, -1, 0, -1, 0);
    run_exp(0, 4, 0, 0, 20, -1, 3, 0, -1, 0);
    for (int r = 0; r < 10; r++) begin
      run_exp($urandom_range(3, 0), $urandom_range(70, 0),
              $urandom_range(40, 0), $urandom_range(10, 0),
              $urandom_range(48, 0), $urandom_range(60, 0) - 10,
              $urandom_range(48, 0), 0, -1,
              $urandom_range(1, 0) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fi_inject_ctrl.md
Name: fi_inject_ctrl

Overview:
- Parametrised successor to the fixed-length fault-free dump wrapper.
- Runs one fault-injection experiment of programmable length on a DUT state bus.
- Applies a configurable fault (bit-flip, stuck-at-0, stuck-at-1) to one bit over a programmable cycle window.
- Compares observed against golden output every cycle, latches the first mismatch, and raises done at the end of the run.

Parameters:
- DATA_W, 64, width of the injected state bus and of the observed/golden buses.
- CNT_W, 16, width of the cycle counter and of all cycle-valued config fields.
- BIT_W, $clog2(DATA_W), width of the bit-select field.

Ports:
- clk  in  1  clock; all state on posedge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  launch a run; sampled only in IDLE or DONE.
- cfg_mode  in  2  00 none, 01 flip, 10 stuck-at-0, 11 stuck-at-1.
- cfg_bit  in  BIT_W  target bit index.
- cfg_inject_cycle  in  CNT_W  first faulty cycle.
- cfg_duration  in  CNT_W  window length; 0 means permanent until run end.
- cfg_run_len  in  CNT_W  total cycles in the run.
- sig_i  in  DATA_W  DUT next-state value before the fault.
- sig_o  out  DATA_W  value written back into DUT state.
- obs_i  in  DATA_W  faulty-run observed output.
- gold_i  in  DATA_W  fault-free reference output for the same cycle.
- clk_counter  out  CNT_W  current run cycle.
- busy  out  1  high in RUN.
- fault_active  out  1  fault window active this cycle.
- mismatch  out  1  sticky: obs_i differed from gold_i.
- mismatch_cycle  out  CNT_W  clk_counter value at the first mismatch.
- done  out  1  level, high in DONE.

Behaviour:
- Reset values (asynchronous): state IDLE, clk_counter 0, busy 0, done 0, mismatch 0, mismatch_cycle 0, shadow config 0 (mode none).
- FSM states and transitions:
  - IDLE --start--> RUN.
  - RUN --(clk_counter == run_len-1)--> DONE.
  - DONE --start--> RUN.
- start is ignored in RUN.
- On the start edge:
  - cfg_* are captured into shadow registers; later cfg_* changes have no effect on the run in progress.
  - clk_counter clears to 0, mismatch clears to 0, mismatch_cycle clears to 0.
- Counting: in RUN, clk_counter increments by 1 per cycle. It holds in DONE. Run length is exactly run_len cycles (counter 0..run_len-1). run_len of 0 behaves as 1.
- Fault window: fault_active is combinational. It is 1 only when all of the following hold:
  - state is RUN;
  - mode is not none;
  - bit < DATA_W;
  - clk_counter >= inject_cycle;
  - duration == 0, or clk_counter < inject_cycle + duration, computed in CNT_W+1 bits so there is no wrap-around.
- sig_o is combinational from sig_i, with zero latency:
  - mask = 1 << bit.
  - flip: sig_i ^ mask.
  - stuck-at-0: sig_i & ~mask.
  - stuck-at-1: sig_i | mask.
  - When fault_active is 0: sig_o = sig_i.
- Compare:
  - In RUN, each cycle, if obs_i != gold_i and mismatch is 0, then on the next edge mismatch is set to 1 and mismatch_cycle takes that cycle's clk_counter.
  - Later mismatches do not overwrite mismatch_cycle.
  - No comparison takes place in IDLE or DONE.
- Final cycle: a mismatch on the last RUN cycle (counter = run_len-1) is still latched, on the same edge that enters DONE.
- done: 1 from the cycle after the last RUN cycle until the next start. mismatch and mismatch_cycle remain valid while done is high.
- inject_cycle >= run_len: no fault is ever applied, and the run still completes normally.
- Reset asserted mid-run: immediate return to IDLE with all outputs at their reset values; sig_o = sig_i.

Decomposition:
- Package fi_pkg:
  - fi_mode_e enum: FI_NONE, FI_FLIP, FI_SA0, FI_SA1.
  - fi_state_e enum: IDLE, RUN, DONE.
- One combinational sub-module, fi_fault_apply: takes (mode, bit, active, sig_i) and produces sig_o. It can be reused per channel in later multi-channel versions.
- FSM, counter, window compare and mismatch latch stay in fi_inject_ctrl.

Test Plan:
- Flip window: DATA_W=64, mode flip, bit 5, inject 10, duration 3, run_len 64, sig_i=0 -> sig_o=0x20 exactly at counter 10..12, else 0; done rises after counter 63.
- Stuck-at-1, permanent: bit 63, inject 0, duration 0, sig_i=0 -> sig_o=0x8000_0000_0000_0000 for all 64 RUN cycles; 0 in DONE.
- Mismatch latch: obs_i != gold_i first at counter 20, again at counter 30 -> mismatch=1 and mismatch_cycle=20 at done.
- Boundary cases, in separate runs:
  - inject 70 with run_len 64 -> fault_active is never 1.
  - bit 64 (out of range, DATA_W=64) -> fault_active is never 1.
  - mismatch only at counter 63 -> mismatch_cycle=63.
- Control robustness:
  - start pulsed mid-run, cfg changed mid-run -> no restart, original config used.
  - rst asserted at counter 15 -> all outputs zero, state IDLE.
  - start in DONE -> counter and mismatch cleared; new run begins.
